muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide encodings and controller state codes.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in a final state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [BIT_WIDTH-1:0] rs1_val,
    input  logic [BIT_WIDTH-1:0] rs2_val,
    input  logic [4:0]           rd_in,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] result,
    output logic [4:0]           rd_out
);

    localparam int CNT_W = $clog2(BIT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2:0]           op_q;
    logic [4:0]           rd_q;
    logic                 neg_a_q;
    logic                 neg_b_q;
    logic                 div_zero_q;
    // acc holds the product high half (multiply) or partial remainder (divide);
    // lo holds the multiplier bits (multiply) or dividend/quotient bits (divide).
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] lo;
    logic [BIT_WIDTH-1:0] opnd;

    logic                 sign_a;
    logic                 sign_b;
    logic [BIT_WIDTH-1:0] mag_a;
    logic [BIT_WIDTH-1:0] mag_b;
    logic [BIT_WIDTH:0]   mul_sum;
    logic [BIT_WIDTH:0]   div_shift;
    logic                 div_ge;
    logic [BIT_WIDTH-1:0] div_rem;
    logic [2*BIT_WIDTH-1:0] prod_fix;
    logic [BIT_WIDTH-1:0] quo_fix;
    logic [BIT_WIDTH-1:0] rem_fix;
    logic [BIT_WIDTH-1:0] fin_result;

    assign busy = (state != ST_IDLE);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sign_a = rs1_val[BIT_WIDTH-1] & a_is_signed(op);
        sign_b = rs2_val[BIT_WIDTH-1] & b_is_signed(op);
        mag_a  = sign_a ? -rs1_val : rs1_val;
        mag_b  = sign_b ? -rs2_val : rs2_val;

        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, lo[BIT_WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_shift[BIT_WIDTH-1:0] - opnd;

        prod_fix = {acc, lo};
        if (neg_a_q ^ neg_b_q) begin
            prod_fix = -prod_fix;
        end
        quo_fix = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo : lo);
        rem_fix = neg_a_q ? -acc : acc;

        case (op_q)
            OP_MUL:                       fin_result = prod_fix[BIT_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*BIT_WIDTH-1:BIT_WIDTH];
            OP_DIV, OP_DIVU:              fin_result = quo_fix;
            default:                      fin_result = rem_fix;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            op_q       <= OP_MUL;
            rd_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            acc        <= '0;
            lo         <= '0;
            opnd       <= '0;
            done       <= 1'b0;
            result     <= '0;
            rd_out     <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            op_q       <= op;
                            rd_q       <= rd_in;
                            neg_a_q    <= sign_a;
                            neg_b_q    <= sign_b;
                            div_zero_q <= (rs2_val == '0);
                            count      <= '0;
                            acc        <= '0;
                            if (op_is_div(op)) begin
                                lo   <= mag_a;
                                opnd <= mag_b;
                            end else begin
                                lo   <= mag_b;
                                opnd <= mag_a;
                            end
                            state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (op_is_div(op_q)) begin
                            acc <= div_ge ? div_rem : div_shift[BIT_WIDTH-1:0];
                            lo  <= {lo[BIT_WIDTH-2:0], div_ge};
                        end else begin
                            acc <= mul_sum[BIT_WIDTH:1];
                            lo  <= {mul_sum[0], lo[BIT_WIDTH-1:1]};
                        end
                        count <= count + CNT_W'(1);
                        if (count == LAST_CNT) begin
                            state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        result <= fin_result;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus
// hand-written busy, flush and reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit #(.BIT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one operation and follows it to done; lat counts edges after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int busy_cnt);
        int e;
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0; lat = -1; busy_cnt = 0; res = 'x; rdo = 'x;
        while (e < 100 && lat < 0) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = e; res = result; rdo = rd_out;
            end else begin
                @(negedge clk);
                e++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bcnt, ndone;
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;

        vecs[0]  = '{OP_MUL,    32'd7,         32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB};
        vecs[1]  = '{OP_MULH,   32'h80000000,  32'h80000000, 5'd2,  32'h40000000};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF,  32'd2,        5'd4,  32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,  32'd2,        5'd5,  32'hFFFFFFFD};
        vecs[5]  = '{OP_REM,    32'hFFFFFFF9,  32'd2,        5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{OP_DIVU,   32'd7,         32'd0,        5'd7,  32'hFFFFFFFF};
        vecs[7]  = '{OP_REM,    32'd5,         32'd0,        5'd8,  32'd5};
        vecs[8]  = '{OP_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd9,  32'h80000000};
        vecs[9]  = '{OP_REM,    32'h80000000,  32'hFFFFFFFF, 5'd10, 32'd0};
        vecs[10] = '{OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 5'd11, 32'd0};
        vecs[11] = '{OP_DIV,    32'hFFFFFFF8,  32'd0,        5'd12, 32'hFFFFFFFF};
        vecs[12] = '{OP_REM,    32'hFFFFFFF8,  32'd0,        5'd13, 32'hFFFFFFF8};
        vecs[13] = '{OP_DIVU,   32'd100,       32'd7,        5'd14, 32'd14};
        vecs[14] = '{OP_REMU,   32'd100,       32'd7,        5'd15, 32'd2};
        vecs[15] = '{OP_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF, 5'd16, 32'd1};
        vecs[16] = '{OP_MULHU,  32'h80000000,  32'd2,        5'd17, 32'd1};
        vecs[17] = '{OP_DIV,    32'd20,        32'hFFFFFFFA, 5'd18, 32'hFFFFFFFD};
        vecs[18] = '{OP_REM,    32'd20,        32'hFFFFFFFA, 5'd19, 32'd2};
        vecs[19] = '{OP_MULH,   32'd7,         32'hFFFFFFFD, 5'd20, 32'hFFFFFFFF};
        vecs[20] = '{OP_MULHU,  32'h00010000,  32'h00010000, 5'd21, 32'd1};
        vecs[21] = '{OP_DIVU,   32'hFFFFFFF9,  32'd2,        5'd22, 32'h7FFFFFFC};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset rd_out", 64'(rd_out), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat, bcnt);
            check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d rd_out", i), 64'(rdo), 64'(vecs[i].rd));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'd33);
        end
        @(negedge clk);
        check("done pulse width", 64'(done), 64'd0);

        // Second start while busy is dropped
        @(negedge clk);
        op = OP_MUL; rs1_val = 32'd6; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = OP_MUL; rs1_val = 32'd100; rs2_val = 32'd100; rd_in = 5'd9; start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        ndone = 0; rdo = '0; res = '0;
        for (int c = 0; c < 70; c++) begin
            if (done) begin
                ndone++; rdo = rd_out; res = result;
            end
            @(negedge clk);
        end
        check("busy-start done count", 64'(ndone), 64'd1);
        check("busy-start rd_out", 64'(rdo), 64'd3);
        check("busy-start result", 64'(res), 64'd42);
        prev_res = 32'd42; prev_rd = 5'd3;

        // Flush at CALC cycle 10, then a fresh DIVU
        @(negedge clk);
        op = OP_DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush no done", 64'(ndone), 64'd0);
        check("flush result held", 64'(result), 64'(prev_res));
        check("flush rd_out held", 64'(rd_out), 64'(prev_rd));
        do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, res, rdo, lat, bcnt);
        check("post-flush result", 64'(res), 64'd14);
        check("post-flush latency", 64'(lat), 64'd33);
        check("post-flush rd_out", 64'(rdo), 64'd5);

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        op = OP_MUL; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush+start no done", 64'(ndone), 64'd0);
        check("flush+start result held", 64'(result), 64'd14);

        // Reset at CALC cycle 20
        op = OP_DIV; rs1_val = 32'd77; rs2_val = 32'd5; rd_in = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid-calc busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-reset busy", 64'(busy), 64'd0);
        check("mid-reset done", 64'(done), 64'd0);
        check("mid-reset result", 64'(result), 64'd0);
        check("mid-reset rd_out", 64'(rd_out), 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("mid-reset no done", 64'(ndone), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
